rs232_tx: RTL
=============

Name: rs232_tx

Overview:
- UART/RS-232 transmitter: serialises one byte per frame onto TXD as 8N1, LSB first.
- Idle line level is high.
- Sits beside the existing receiver inside top; drives the top-level TXD pin.
- Accepts bytes over a valid/ready handshake from the local core (echo path or command responder).

Parameters:
- CLKS_PER_BIT, 10, clk cycles per serial bit; legal range >= 2; 100 ns bit at a 100 MHz clk.
- DATA_BITS, 8, payload bits per frame; legal range 5..8.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-low (0 = reset).
- tx_data  input  DATA_BITS  byte to send; sampled only on accept.
- tx_valid  input  1  core offers tx_data.
- tx_ready  output  1  transmitter can accept; high only in IDLE.
- TXD  output  1  serial line, registered.
- tx_busy  output  1  high from the accept cycle until the stop bit completes.

Behaviour:
- Reset (rst=0, asynchronous):
  - TXD=1, tx_ready=1, tx_busy=0.
  - State IDLE; bit counter and baud counter cleared.
  - A reset mid-frame forces TXD high immediately; the partial frame is abandoned.
- Accept: tx_valid=1 and tx_ready=1 on a rising edge at cycle N.
  - tx_data latched into the shift register.
  - tx_ready=0 and tx_busy=1 from cycle N+1.
  - TXD=0 (start bit) from cycle N+1.
- States: IDLE -> START -> DATA -> STOP -> IDLE.
  - Each state holds TXD for exactly CLKS_PER_BIT cycles.
  - Baud counter runs 0..CLKS_PER_BIT-1, restarts at 0 on each state entry, and wraps at CLKS_PER_BIT-1 to advance.
- DATA:
  - Sends bit 0 first, shifting right.
  - Bit counter runs 0..DATA_BITS-1; exits to STOP after bit DATA_BITS-1 completes.
- STOP:
  - TXD=1 for CLKS_PER_BIT cycles.
  - On the last stop cycle, state returns to IDLE: tx_ready=1 and tx_busy=0 from the next cycle.
- Frame length: (1+DATA_BITS+1)*CLKS_PER_BIT cycles; 100 cycles at the defaults.
- Back-to-back frames:
  - tx_valid held high re-accepts in the first IDLE cycle.
  - The next start bit follows the stop bit with exactly 1 extra idle cycle.
  - Sustained throughput is one frame per frame length + 1 cycles.
- tx_valid while busy: ignored, with no buffering. The core must hold tx_valid until it sees tx_ready.
- tx_data changes after accept have no effect on the frame in flight.
- TXD never glitches; it changes only on a baud-counter boundary or at reset.

Optional Feature:
- Macro: RS232_TX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP.
  - TXD carries even parity: the XOR of the latched data bits, so a 1 is sent when the data has an odd count of ones.
  - Frame = (DATA_BITS+3)*CLKS_PER_BIT cycles; 110 at the defaults.
- Undefined: no PARITY state; 8N1 frame as above.

Decomposition:
- Package rs232_pkg:
  - State enum: IDLE, START, DATA, PARITY, STOP.
  - Default CLKS_PER_BIT and DATA_BITS constants.
  - IDLE_LEVEL=1.
  - Shared with the receiver.
- Sub-module rs232_baud_gen:
  - Counter parameterised by CLKS_PER_BIT.
  - Inputs clk, rst, restart; output bit_done pulse on the final cycle of each bit.
  - Reusable by the receiver.

Test Plan:
1. Reset check: hold rst=0 for 10 cycles -> TXD=1, tx_ready=1, tx_busy=0; assert rst=0 mid-frame -> TXD=1 in the same cycle, IDLE after release.
2. Send 0x43 at defaults:
   - TXD sequence, 10 cycles each: 0,1,1,0,0,0,0,1,0,1.
   - tx_ready low for 100 cycles.
   - A line-sampling model (e.g. a loop into the receiver) recovers 0x43.
3. Back-to-back send of 0x00 then 0xFF with tx_valid held high -> two frames; second start bit begins 101 cycles after the first start bit; data bits all 0, then all 1.
4. Busy-period stimulus: pulse tx_valid with 0xAA during frame bit 3, then change tx_data to 0x55 mid-frame -> current frame is unchanged and no extra frame is sent.
5. CLKS_PER_BIT=2, DATA_BITS=5, send 0x15 -> bits 1,0,1,0,1, each 2 cycles; frame length 14 cycles.
6. RS232_TX_PARITY_EN defined:
   - Send 0x07 -> parity bit 1 after bit 7; frame length 110 cycles.
   - Send 0x03 -> parity bit 0.

Source files
------------

// File: rtl/rs232_pkg.sv
// Shared UART definitions for the transmitter and the receiver: state encoding,
// default timing constants and the idle line level.
package rs232_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rs232_state_e;

  localparam int   DEF_CLKS_PER_BIT = 10;
  localparam int   DEF_DATA_BITS    = 8;
  localparam logic IDLE_LEVEL       = 1'b1;

endpackage

// File: rtl/rs232_baud_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and pulses bit_done on the final
// cycle of each bit; restart holds it at zero so every state entry starts a full bit.
module rs232_baud_gen
  import rs232_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic bit_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (restart || (cnt == LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign bit_done = (cnt == LAST) && !restart;

endmodule

// File: rtl/rs232_tx.sv
// RS-232 transmitter: one frame per accepted byte, LSB first, registered TXD.
// Define RS232_TX_PARITY_EN to insert an even-parity bit between data and stop.
module rs232_tx
  import rs232_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int DATA_BITS    = DEF_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 TXD,
  output logic                 tx_busy
);

  localparam int BW = $clog2(DATA_BITS);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  rs232_state_e         state, state_nxt;
  logic [BW-1:0]        bit_cnt, bit_cnt_nxt;
  logic [DATA_BITS-1:0] shreg, shreg_nxt;
  logic                 txd_nxt;
  logic                 bit_done;
  logic                 accept;
`ifdef RS232_TX_PARITY_EN
  logic                 parity, parity_nxt;
`endif

  assign tx_ready = (state == IDLE);
  assign tx_busy  = (state != IDLE);
  assign accept   = tx_valid && tx_ready;

  rs232_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .rst     (rst),
    .restart (state == IDLE),
    .bit_done(bit_done)
  );

  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    shreg_nxt   = shreg;
    txd_nxt     = TXD;
`ifdef RS232_TX_PARITY_EN
    parity_nxt  = parity;
`endif
    case (state)
      IDLE: begin
        txd_nxt = IDLE_LEVEL;
        if (accept) begin
          state_nxt   = START;
          txd_nxt     = 1'b0;
          shreg_nxt   = tx_data;
          bit_cnt_nxt = '0;
`ifdef RS232_TX_PARITY_EN
          parity_nxt  = ^tx_data;
`endif
        end
      end
      START: begin
        if (bit_done) begin
          state_nxt = DATA;
          txd_nxt   = shreg[0];
          shreg_nxt = shreg >> 1;
        end
      end
      DATA: begin
        if (bit_done) begin
          if (bit_cnt == LAST_BIT) begin
`ifdef RS232_TX_PARITY_EN
            state_nxt = PARITY;
            txd_nxt   = parity;
`else
            state_nxt = STOP;
            txd_nxt   = IDLE_LEVEL;
`endif
          end else begin
            bit_cnt_nxt = bit_cnt + BW'(1);
            txd_nxt     = shreg[0];
            shreg_nxt   = shreg >> 1;
          end
        end
      end
      PARITY: begin
        if (bit_done) begin
          state_nxt = STOP;
          txd_nxt   = IDLE_LEVEL;
        end
      end
      STOP: begin
        if (bit_done) begin
          state_nxt = IDLE;
          txd_nxt   = IDLE_LEVEL;
        end
      end
      default: begin
        state_nxt = IDLE;
        txd_nxt   = IDLE_LEVEL;
      end
    endcase
  end

  // Control state: reset forces the line idle at once, abandoning any frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      bit_cnt <= '0;
      TXD     <= IDLE_LEVEL;
    end else begin
      state   <= state_nxt;
      bit_cnt <= bit_cnt_nxt;
      TXD     <= txd_nxt;
    end
  end

  // Payload holding registers; only read after a fresh load on accept.
  always_ff @(posedge clk) begin
    shreg  <= shreg_nxt;
`ifdef RS232_TX_PARITY_EN
    parity <= parity_nxt;
`endif
  end

endmodule
